// File: rtl/prog_clock_div.sv
// prog_clock_div: runtime-programmable, glitch-free 50%-duty clock divider.
//
// clock_out is a registered square wave whose half-period is (div_active+1)
// input clocks. New divide values are staged in div_pend and only become
// active at the end of a full output period (the 1->0 toggle) or while idle,
// so a reprogram never produces a shortened high or low phase. Start and stop
// only happen with clock_out low; a stop request during the high phase lets
// that phase run to completion first.
//
// Optional feature macro: PROG_CLOCK_DIV_PHASE_FLIP_EN
//   When defined, a phase_flip strobe suppresses the next 1->0 toggle, which
//   holds clock_out high for one extra half-period (a 180-degree phase shift).
//   When undefined, phase_flip is accepted but ignored.

module prog_clock_div #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEFAULT_DIV = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   input  logic             phase_flip,
   output logic             clock_out,
   output logic             tick,
   output logic             div_ack,
   output logic             running
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);

   // Control state and half-period counter.
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Divide value in force, plus the staged value waiting for a safe point.
   logic [WIDTH-1:0] div_active_q, div_active_d;
   logic [WIDTH-1:0] div_pend_q, div_pend_d;
   logic             pend_valid_q, pend_valid_d;

   // Registered outputs.
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic             running_q, running_d;

   // Decode helpers.
   logic             at_limit;     // counter has reached the active half-period count
   logic [WIDTH-1:0] start_div;    // divide value governing the IDLE->RUN edge
   logic             apply;        // staged divide value becomes active on this edge
   logic             flip_pending; // a phase flip is armed for the next falling toggle

`ifdef PROG_CLOCK_DIV_PHASE_FLIP_EN
   logic             flip_req_q, flip_req_d;

   assign flip_pending = flip_req_q;
`else
   logic             unused_phase_flip;

   assign unused_phase_flip = phase_flip;
   assign flip_pending      = 1'b0;
`endif

   assign at_limit  = (cnt_q == div_active_q);
   // A value staged while idle is applied on the very edge that starts the
   // divider, so the first half-period must already use it; otherwise the
   // counter could start beyond a smaller new limit and run away.
   assign start_div = pend_valid_q ? div_pend_q : div_active_q;

   // Next-state logic: run/stop sequencing, toggle rule and divide staging.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clk_d        = clk_q;
      tick_d       = 1'b0;
      ack_d        = 1'b0;
      apply        = 1'b0;
      div_active_d = div_active_q;
      div_pend_d   = div_pend_q;
      pend_valid_d = pend_valid_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            // Any idle edge is a safe point to switch divide values.
            apply = pend_valid_q;
            if (enable) begin
               // The start edge is also the first counting edge.
               state_d = RUN;
               if (start_div == '0) begin
                  clk_d  = 1'b1;
                  tick_d = 1'b1;
               end else begin
                  cnt_d = WIDTH'(1);
               end
            end
         end

         RUN, STOPPING: begin
            if (!enable && !clk_q) begin
               // Output is already low: stopping here cannot clip a pulse.
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               // Either running, or finishing the high phase before stopping.
               state_d = enable ? RUN : STOPPING;
               if (!at_limit) begin
                  cnt_d = cnt_q + WIDTH'(1);
               end else begin
                  cnt_d = '0;
                  if (!clk_q) begin
                     // Rising toggle: start of a new output period.
                     clk_d  = 1'b1;
                     tick_d = 1'b1;
                  end else if (flip_pending) begin
                     // Suppressed falling toggle: stay high another half-period.
                     // Any staged divide value waits for the next real fall.
                     clk_d = 1'b1;
                  end else begin
                     // Falling toggle: end of a full period, the apply point.
                     clk_d = 1'b0;
                     apply = pend_valid_q;
                     if (!enable) begin
                        state_d = IDLE;
                     end
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase

      // The old staged value is applied first; a load on the same edge is
      // captured afterwards and stays pending for the next safe point.
      if (apply) begin
         div_active_d = div_pend_q;
         pend_valid_d = 1'b0;
         ack_d        = 1'b1;
      end
      if (div_load) begin
         div_pend_d   = div_in;
         pend_valid_d = 1'b1;
      end

      running_d = (state_d != IDLE);

`ifdef PROG_CLOCK_DIV_PHASE_FLIP_EN
      flip_req_d = flip_req_q;
      // The request is consumed at the falling-toggle point it suppresses.
      if ((state_q != IDLE) && clk_q && at_limit) begin
         flip_req_d = 1'b0;
      end
      // Requests only count while the divider is running.
      if (phase_flip && (state_q != IDLE)) begin
         flip_req_d = 1'b1;
      end
      if (state_d == IDLE) begin
         flip_req_d = 1'b0;
      end
`endif
   end

   // Register all state and outputs; reset clears everything immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         clk_q        <= 1'b0;
         tick_q       <= 1'b0;
         ack_q        <= 1'b0;
         running_q    <= 1'b0;
         div_active_q <= DIV_RESET;
         div_pend_q   <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clk_q        <= clk_d;
         tick_q       <= tick_d;
         ack_q        <= ack_d;
         running_q    <= running_d;
         div_active_q <= div_active_d;
         div_pend_q   <= div_pend_d;
         pend_valid_q <= pend_valid_d;
      end
   end

`ifdef PROG_CLOCK_DIV_PHASE_FLIP_EN
   // Armed phase-flip request; lost on reset like any other pending action.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flip_req_q <= 1'b0;
      end else begin
         flip_req_q <= flip_req_d;
      end
   end
`endif

   assign clock_out = clk_q;
   assign tick      = tick_q;
   assign div_ack   = ack_q;
   assign running   = running_q;

endmodule
